// File: rtl/mips_pkg.sv
// Shared types and constants for the operand fetch slice.
// Holds the issue FSM state enum, register-number width and data width.
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_NUM_W = 5;

    localparam logic [REG_NUM_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

endpackage

// File: rtl/operand_fwd.sv
// Last-write slot plus per-operand select for both source operands.
// Ports: clock/reset_n, write/wnum/wdata (array write port), rs1/rs2,
// rdata1/rdata2 (array read data), op1/op2 (resolved), hit (slot collision).
// Macro OPFETCH_BYPASS_EN: forward slot data instead of reporting a hit.
module operand_fwd
    import mips_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 write,
    input  logic [REG_NUM_W-1:0] wnum,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_NUM_W-1:0] rs1,
    input  logic [REG_NUM_W-1:0] rs2,
    input  logic [DATA_W-1:0]    rdata1,
    input  logic [DATA_W-1:0]    rdata2,
    output logic [DATA_W-1:0]    op1,
    output logic [DATA_W-1:0]    op2,
    output logic                 hit
);

    logic                 lw_valid;
    logic [REG_NUM_W-1:0] lw_num;
    logic [DATA_W-1:0]    lw_data;
    logic                 hit1;
    logic                 hit2;

    // The array's registered read lags a write by one edge; the slot
    // remembers that write so it can cover the gap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lw_valid <= 1'b0;
            lw_num   <= REG_ZERO;
            lw_data  <= '0;
        end else begin
            lw_valid <= write;
            lw_num   <= wnum;
            lw_data  <= wdata;
        end
    end

    assign hit1 = lw_valid & (lw_num == rs1) & (rs1 != REG_ZERO);
    assign hit2 = lw_valid & (lw_num == rs2) & (rs2 != REG_ZERO);

`ifdef OPFETCH_BYPASS_EN
    assign hit = 1'b0;
    assign op1 = (rs1 == REG_ZERO) ? '0 : (hit1 ? lw_data : rdata1);
    assign op2 = (rs2 == REG_ZERO) ? '0 : (hit2 ? lw_data : rdata2);
`else
    assign hit = hit1 | hit2;
    assign op1 = (rs1 == REG_ZERO) ? '0 : rdata1;
    assign op2 = (rs2 == REG_ZERO) ? '0 : rdata2;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts an issue request, reads the register array,
// and hands resolved operands to execute (IDLE -> READ -> VALID).
// Ports: clock/reset_n, in_* issue handshake, flush, wb_* writeback,
// rnum*/rdata* array read, write/wnum/wdata array write, out_* to execute.
// Macro OPFETCH_BYPASS_EN: enables last-write forwarding (else 1-cycle stall).
module operand_fetch #(
    parameter int DATA_W = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [mips_pkg::REG_NUM_W-1:0] in_rs1,
    input  logic [mips_pkg::REG_NUM_W-1:0] in_rs2,
    input  logic [mips_pkg::REG_NUM_W-1:0] in_rd,
    input  logic                          flush,
    input  logic                          wb_valid,
    input  logic [mips_pkg::REG_NUM_W-1:0] wb_num,
    input  logic [DATA_W-1:0]             wb_data,
    output logic [mips_pkg::REG_NUM_W-1:0] rnum1,
    output logic [mips_pkg::REG_NUM_W-1:0] rnum2,
    input  logic [DATA_W-1:0]             rdata1,
    input  logic [DATA_W-1:0]             rdata2,
    output logic                          write,
    output logic [mips_pkg::REG_NUM_W-1:0] wnum,
    output logic [DATA_W-1:0]             wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_op1,
    output logic [DATA_W-1:0]             out_op2,
    output logic [mips_pkg::REG_NUM_W-1:0] out_rd
);

    import mips_pkg::*;

    state_t               state_q;
    state_t               state_d;
    logic [REG_NUM_W-1:0] rs1_q;
    logic [REG_NUM_W-1:0] rs2_q;
    logic [REG_NUM_W-1:0] rd_q;
    logic                 stall;
    logic                 handoff;
    logic                 accept;

    assign write = wb_valid & (wb_num != REG_ZERO);
    assign wnum  = wb_num;
    assign wdata = wb_data;

    assign rnum1  = rs1_q;
    assign rnum2  = rs2_q;
    assign out_rd = rd_q;

    assign out_valid = (state_q == ST_VALID) & ~flush & ~stall;
    assign handoff   = out_valid & out_ready;
    assign in_ready  = ~flush & ((state_q == ST_IDLE) | handoff);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (accept) state_d = ST_READ;
                ST_READ:  state_d = ST_VALID;
                ST_VALID: if (handoff) state_d = accept ? ST_READ : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rs1_q   <= REG_ZERO;
            rs2_q   <= REG_ZERO;
            rd_q    <= REG_ZERO;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                rd_q  <= in_rd;
            end
        end
    end

    operand_fwd u_fwd (
        .clock   (clock),
        .reset_n (reset_n),
        .write   (write),
        .wnum    (wnum),
        .wdata   (wdata),
        .rs1     (rs1_q),
        .rs2     (rs2_q),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .op1     (out_op1),
        .op2     (out_op2),
        .hit     (stall)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register array.
// Build with or without OPFETCH_BYPASS_EN; expectations follow the macro.
module tb_operand_fetch;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic [4:0]  rnum1;
    logic [4:0]  rnum2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        write;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;

    logic [31:0] regs [0:31];

    int pass_cnt = 0;
    int total    = 0;

    operand_fetch #(.DATA_W(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_num    (wb_num),
        .wb_data   (wb_data),
        .rnum1     (rnum1),
        .rnum2     (rnum2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .write     (write),
        .wnum      (wnum),
        .wdata     (wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register array: registered read returns pre-write contents.
    always @(posedge clock) begin
        if (write) regs[wnum] <= wdata;
        rdata1 <= regs[rnum1];
        rdata2 <= regs[rnum2];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wb(input logic [4:0] n, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_num   = n;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d);
        in_valid = 1'b1;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL rst_valid: got %b exp 0", out_valid);
        else pass_cnt++;
        total++;
        if (rnum1 !== 5'd0 || rnum2 !== 5'd0 || out_rd !== 5'd0)
            $display("FAIL rst_regs: got %0d/%0d/%0d exp 0/0/0",
                     rnum1, rnum2, out_rd);
        else pass_cnt++;
        reset_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL rst_ready: got %b exp 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        wb(5'd5, 32'h11);
        wb(5'd6, 32'h22);
        out_ready = 1'b1;
        issue(5'd5, 5'd6, 5'd7);
        #1;
        total++;
        if (out_valid !== 1'b0 || rnum1 !== 5'd5 || rnum2 !== 5'd6)
            $display("FAIL basic_read: got v=%b r=%0d/%0d exp 0 5/6",
                     out_valid, rnum1, rnum2);
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_op1 !== 32'h11 ||
            out_op2 !== 32'h22 || out_rd !== 5'd7)
            $display("FAIL basic_out: got v=%b %h %h rd=%0d exp 1 11 22 7",
                     out_valid, out_op1, out_op2, out_rd);
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL basic_idle: got v=%b r=%b exp 0 1",
                     out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_collision;
        out_ready = 1'b1;
        issue(5'd5, 5'd6, 5'd8);
        wb_valid = 1'b1;
        wb_num   = 5'd5;
        wb_data  = 32'hAA;
        tick();
        wb_valid = 1'b0;
        #1;
`ifdef OPFETCH_BYPASS_EN
        total++;
        if (out_valid !== 1'b1 || out_op1 !== 32'hAA || out_op2 !== 32'h22)
            $display("FAIL coll_byp: got v=%b %h %h exp 1 aa 22",
                     out_valid, out_op1, out_op2);
        else pass_cnt++;
        tick();
`else
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL coll_stall: got v=%b r=%b exp 0 0",
                     out_valid, in_ready);
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_op1 !== 32'hAA || out_op2 !== 32'h22)
            $display("FAIL coll_after: got v=%b %h %h exp 1 aa 22",
                     out_valid, out_op1, out_op2);
        else pass_cnt++;
        tick();
`endif
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL coll_idle: got v=%b r=%b exp 0 1",
                     out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_zero;
        wb_valid = 1'b1;
        wb_num   = 5'd0;
        wb_data  = 32'hFFFF;
        #1;
        total++;
        if (write !== 1'b0)
            $display("FAIL zero_write: got %b exp 0", write);
        else pass_cnt++;
        tick();
        wb_valid = 1'b0;
        issue(5'd0, 5'd6, 5'd1);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_op1 !== 32'h0 || out_op2 !== 32'h22)
            $display("FAIL zero_op: got v=%b %h %h exp 1 0 22",
                     out_valid, out_op1, out_op2);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd9);
        tick();
        in_valid = 1'b1;
        in_rs1   = 5'd5;
        in_rs2   = 5'd6;
        in_rd    = 5'd10;
        wb_valid = 1'b1;
        wb_num   = 5'd6;
        wb_data  = 32'h33;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_op2 !== 32'h22 || in_ready !== 1'b0)
            $display("FAIL stall_v1: got v=%b %h r=%b exp 1 22 0",
                     out_valid, out_op2, in_ready);
        else pass_cnt++;
        tick();
        wb_valid = 1'b0;
        #1;
`ifdef OPFETCH_BYPASS_EN
        total++;
        if (out_valid !== 1'b1 || out_op2 !== 32'h33 || in_ready !== 1'b0)
            $display("FAIL stall_v2: got v=%b %h r=%b exp 1 33 0",
                     out_valid, out_op2, in_ready);
        else pass_cnt++;
`else
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL stall_v2: got v=%b r=%b exp 0 0",
                     out_valid, in_ready);
        else pass_cnt++;
`endif
        tick();
        total++;
        if (out_valid !== 1'b1 || out_op2 !== 32'h33 ||
            out_rd !== 5'd9 || in_ready !== 1'b0)
            $display("FAIL stall_v3: got v=%b %h rd=%0d r=%b exp 1 33 9 0",
                     out_valid, out_op2, out_rd, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL stall_hand: got %b exp 1", in_ready);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_rd !== 5'd10)
            $display("FAIL stall_next: got v=%b rd=%0d exp 0 10",
                     out_valid, out_rd);
        else pass_cnt++;
        tick();
        tick();
    endtask

    task automatic test_back_to_back;
        int n_out = 0;
        int n_acc = 0;
        int first_c = -1;
        int gap = 0;
        logic acc;
        logic [4:0] rd_seen [0:1];
        logic [31:0] op1_seen [0:1];
        logic [31:0] op2_seen [0:1];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_rs1    = 5'd5;
        in_rs2    = 5'd6;
        in_rd     = 5'd11;
        for (int c = 0; c < 10; c++) begin
            #1;
            acc = in_valid & in_ready;
            if (out_valid & out_ready) begin
                if (n_out < 2) begin
                    rd_seen[n_out]  = out_rd;
                    op1_seen[n_out] = out_op1;
                    op2_seen[n_out] = out_op2;
                end
                if (first_c < 0) first_c = c;
                else gap = c - first_c;
                n_out++;
            end
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    in_rs1 = 5'd6;
                    in_rs2 = 5'd5;
                    in_rd  = 5'd12;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        total++;
        if (n_acc !== 2 || n_out !== 2)
            $display("FAIL b2b_count: got acc=%0d out=%0d exp 2 2",
                     n_acc, n_out);
        else pass_cnt++;
        total++;
        if (gap !== 2)
            $display("FAIL b2b_gap: got %0d exp 2", gap);
        else pass_cnt++;
        total++;
        if (n_out < 2 || rd_seen[0] !== 5'd11 || rd_seen[1] !== 5'd12)
            $display("FAIL b2b_rd: got n=%0d exp rd 11 then 12", n_out);
        else pass_cnt++;
        total++;
        if (n_out < 2 || op1_seen[0] !== 32'hAA || op2_seen[0] !== 32'h33 ||
            op1_seen[1] !== 32'h33 || op2_seen[1] !== 32'hAA)
            $display("FAIL b2b_ops: got n=%0d exp aa/33 then 33/aa", n_out);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        issue(5'd5, 5'd6, 5'd13);
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL flush_cyc: got r=%b v=%b exp 0 0",
                     in_ready, out_valid);
        else pass_cnt++;
        tick();
        flush = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_idle: got v=%b r=%b exp 0 1",
                     out_valid, in_ready);
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_drop: got %b exp 0", out_valid);
        else pass_cnt++;
        out_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd14);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_rd !== 5'd14)
            $display("FAIL rstv_pre: got v=%b rd=%0d exp 1 14",
                     out_valid, out_rd);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_rd !== 5'd0)
            $display("FAIL rstv_async: got v=%b rd=%0d exp 0 0",
                     out_valid, out_rd);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstv_idle: got v=%b r=%b exp 0 1",
                     out_valid, in_ready);
        else pass_cnt++;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL rstv_drop: got %b exp 0", out_valid);
        else pass_cnt++;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_num    = '0;
        wb_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_collision();
        test_zero();
        test_stall();
        test_back_to_back();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, default 32, operand/register data width; only 32 is supported.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 in_valid / in_ready  in / out  1 / 1  issue handshake; request accepted on an edge where both are high.
REQ-005 in_rs1, in_rs2, in_rd  in  5 each  source and destination register numbers of the request.
REQ-006 flush  in  1  discards any request held in the block.
REQ-007 wb_valid, wb_num, wb_data  in  1, 5, 32  writeback request from the retire stage.
REQ-008 rnum1, rnum2  out  5 each  register-array read addresses; the array returns data one edge later.
REQ-009 rdata1, rdata2  in  32 each  registered read data from the register array.
REQ-010 write, wnum, wdata  out  1, 5, 32  register-array write port.
REQ-011 out_valid / out_ready  out / in  1 / 1  operand handshake toward execute.
REQ-012 out_op1, out_op2, out_rd  out  32, 32, 5  resolved operands and the passed-through destination.

Function
REQ-013 States: IDLE, READ and VALID.
REQ-014 IDLE: in_ready=1; on accept, latch rs1/rs2/rd into registers driving rnum1/rnum2/out_rd, then go to READ.
REQ-015 READ lasts exactly one cycle (array samples rnum), then goes to VALID.
REQ-016 VALID: out_valid=1 (subject to REQ-026); on out_valid&out_ready, go to IDLE, or to READ if a new request is accepted the same edge.
REQ-017 in_ready = ~flush & (IDLE | (VALID & out_valid & out_ready)).
REQ-018 Latency from accept edge to first out_valid cycle is 2 cycles; peak throughput is 1 request per 2 cycles.
REQ-019 rnum1/rnum2 are held stable from accept until handoff.
REQ-020 While in VALID, operands track the current register contents and are not snapshotted.
REQ-021 Write port is combinational: write = wb_valid & (wb_num!=0); wnum=wb_num; wdata=wb_data.
REQ-022 Writes to register 0 are suppressed.
REQ-023 Last-write slot (lw_valid, lw_num, lw_data) is updated every edge from {write, wnum, wdata}.
REQ-024 out_op1 = 0 if rs1==0; else lw_data if lw_valid & lw_num==rs1 (bypass); else rdata1.
REQ-025 out_op2 follows the same rule using rs2.
REQ-026 flush: next state IDLE regardless of current state; out_valid=0 in the flush cycle; flush overrides a simultaneous accept or handoff.
REQ-027 Writeback is never stalled; there is no wb_ready.

Reset
REQ-028 While reset_n=0: state IDLE, rnum1/rnum2/out_rd = 0, lw_valid=0, out_valid=0; in_ready=1 once reset_n is released.
REQ-029 A request accepted before reset is lost.
REQ-030 Reset does not clear the register array.

Configuration
REQ-031 With macro OPFETCH_BYPASS_EN defined, the REQ-024/025 bypass is compiled in.
REQ-032 Without OPFETCH_BYPASS_EN, a last-write slot hit on a nonzero rs1 or rs2 in VALID forces out_valid=0 for that cycle only; the next cycle uses rdata. The added latency is 1 cycle per collision.

Structure
REQ-033 Shared package mips_pkg holds the state enum, REG_ZERO=5'd0, DATA_W and REG_NUM_W=5.
REQ-034 One sub-module, operand_fwd, holds the last-write slot and the per-operand select; it is instantiated once and serves both operands.

Verification
REQ-035 Reg 5=0x11, reg 6=0x22; issue rs1=5, rs2=6, rd=7 with out_ready=1 -> out_valid 2 cycles after accept; op1=0x11, op2=0x22, out_rd=7.
REQ-036 Writeback to reg 5 with value 0xAA during the READ cycle -> with macro, op1=0xAA in the first VALID cycle; without macro, out_valid low 1 cycle, then op1=0xAA.
REQ-037 rs1=0, with a prior writeback to reg 0 of 0xFFFF -> write=0 and op1=0.
REQ-038 out_ready=0 for 3 cycles while reg 6 is written 0x33 -> op2 shows 0x33 before handoff and in_ready stays 0 until the handoff.
REQ-039 Back-to-back: in_valid held with 2 requests, out_ready=1 -> accepts on handoff edges, outputs every 2 cycles, no request lost or duplicated.
REQ-040 flush during READ, and separately reset_n low during VALID -> out_valid=0 next cycle, state IDLE, no output for the dropped request.
